// File: rtl/led_pkg.sv
// Shared definitions for the WS2812 frame path: sequencer state encoding,
// GRB packing helper and serializer timing constants used alongside led_control.
// No ports; imported by led_frame_sequencer and pixel_scaler.
package led_pkg;

    // Serializer timing, kept identical to led_control.
    localparam int BITS_PER_PIXEL = 24;
    localparam int LATCH_CYCLES   = 5000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_RD,
        ST_PRESENT,
        ST_XMIT,
        ST_FLUSH
    } seq_state_e;

    // WS2812 parts shift green first, then red, then blue.
    function automatic logic [23:0] grb_pack(input logic [7:0] r,
                                             input logic [7:0] g,
                                             input logic [7:0] b);
        return {g, r, b};
    endfunction

endpackage

// File: rtl/pixel_scaler.sv
// Combinational RGB x brightness scaling with GRB reorder.
// Ports: rgb {R,G,B} in, brightness in, grb {G',R',B'} out; chan' = (chan*brightness)>>8.
// Pure logic, zero latency, no flow control.
module pixel_scaler (
    input  logic [23:0] rgb,
    input  logic [7:0]  brightness,
    output logic [23:0] grb
);
    import led_pkg::*;

    logic [15:0] r_prod;
    logic [15:0] g_prod;
    logic [15:0] b_prod;

    // Truncating upper byte of the 16-bit product: full scale 255 maps 255 -> 254.
    always_comb begin
        r_prod = 16'(rgb[23:16]) * 16'(brightness);
        g_prod = 16'(rgb[15:8])  * 16'(brightness);
        b_prod = 16'(rgb[7:0])   * 16'(brightness);
        grb    = grb_pack(r_prod[15:8], g_prod[15:8], b_prod[15:8]);
    end

endmodule

// File: rtl/led_frame_sequencer.sv
// Frame sequencer: reads NUM_LEDS pixels, scales them, and feeds led_control one GRB word at a time.
// Ports: frame_req/brightness in; rd_en/rd_addr/rd_data frame-buffer port; drv_* serializer controls;
// frame_busy/frame_done/error status. Prefetches the next pixel while the current one shifts out.
module led_frame_sequencer #(
    parameter int NUM_LEDS       = 24,
    parameter int RD_LATENCY     = 2,
    parameter int ACCEPT_TIMEOUT = 16384,
    localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_req,
    input  logic [7:0]    brightness,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [23:0]   rd_data,
    output logic [23:0]   drv_data,
    output logic          drv_valid,
    output logic          drv_last,
    input  logic          drv_busy,
    input  logic          drv_pixel_lit,
    output logic          frame_busy,
    output logic          frame_done,
    output logic          error
);
    import led_pkg::*;

    localparam int TW = $clog2(ACCEPT_TIMEOUT + 1);

    seq_state_e            state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [7:0]            bright_q, bright_d;
    logic [RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
    logic [23:0]           drv_data_q, drv_data_d;
    logic [23:0]           pf_data_q, pf_data_d;
    logic                  pf_vld_q, pf_vld_d;
    logic                  pf_issue_q, pf_issue_d;
    logic                  lit_seen_q, lit_seen_d;
    logic [TW-1:0]         to_cnt_q, to_cnt_d;
    logic                  frame_busy_q, frame_busy_d;
    logic                  frame_done_q, frame_done_d;
    logic                  error_q, error_d;

    logic [23:0] scaled_grb;
    logic        last_pix;
    logic        rd_ret;
    logic        lit_go;

    pixel_scaler u_scaler (
        .rgb        (rd_data),
        .brightness (bright_q),
        .grb        (scaled_grb)
    );

    assign last_pix = (idx_q == AW'(NUM_LEDS - 1));
    // rd_pipe tracks outstanding reads; the top bit marks the cycle rd_data is valid.
    assign rd_ret   = rd_pipe_q[RD_LATENCY-1];
    // A completion that arrives before the prefetch returns is remembered, not lost.
    assign lit_go   = drv_pixel_lit | lit_seen_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            bright_q     <= '0;
            rd_pipe_q    <= '0;
            drv_data_q   <= '0;
            pf_data_q    <= '0;
            pf_vld_q     <= 1'b0;
            pf_issue_q   <= 1'b0;
            lit_seen_q   <= 1'b0;
            to_cnt_q     <= '0;
            frame_busy_q <= 1'b0;
            frame_done_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            bright_q     <= bright_d;
            rd_pipe_q    <= rd_pipe_d;
            drv_data_q   <= drv_data_d;
            pf_data_q    <= pf_data_d;
            pf_vld_q     <= pf_vld_d;
            pf_issue_q   <= pf_issue_d;
            lit_seen_q   <= lit_seen_d;
            to_cnt_q     <= to_cnt_d;
            frame_busy_q <= frame_busy_d;
            frame_done_q <= frame_done_d;
            error_q      <= error_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        bright_d     = bright_q;
        rd_pipe_d    = (rd_pipe_q << 1) | RD_LATENCY'(rd_en);
        drv_data_d   = drv_data_q;
        pf_data_d    = pf_data_q;
        pf_vld_d     = pf_vld_q;
        pf_issue_d   = 1'b0;
        lit_seen_d   = lit_seen_q;
        to_cnt_d     = '0;
        frame_busy_d = frame_busy_q;
        frame_done_d = 1'b0;
        error_d      = error_q;

        // Any read returning outside WAIT_RD is a prefetch of the following pixel.
        if (rd_ret && state_q != ST_WAIT_RD) begin
            pf_data_d = scaled_grb;
            pf_vld_d  = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_req) begin
                    state_d      = ST_FETCH;
                    bright_d     = brightness;
                    idx_d        = '0;
                    frame_busy_d = 1'b1;
                    error_d      = 1'b0;
                    pf_vld_d     = 1'b0;
                    lit_seen_d   = 1'b0;
                end
            end
            ST_FETCH: state_d = ST_WAIT_RD;
            ST_WAIT_RD: begin
                if (rd_ret) begin
                    drv_data_d = scaled_grb;
                    state_d    = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                to_cnt_d = to_cnt_q + TW'(1);
                // Busy rises the cycle after the serializer takes the word.
                if (drv_busy) begin
                    state_d    = ST_XMIT;
                    pf_issue_d = !last_pix;
                end else if (to_cnt_q == TW'(ACCEPT_TIMEOUT - 1)) begin
                    state_d      = ST_IDLE;
                    error_d      = 1'b1;
                    frame_done_d = 1'b1;
                    frame_busy_d = 1'b0;
                end
            end
            ST_XMIT: begin
                if (drv_pixel_lit) lit_seen_d = 1'b1;
                if (lit_go && last_pix) begin
                    state_d    = ST_FLUSH;
                    lit_seen_d = 1'b0;
                end else if (lit_go && pf_vld_q) begin
                    state_d    = ST_PRESENT;
                    idx_d      = idx_q + AW'(1);
                    drv_data_d = pf_data_q;
                    pf_vld_d   = 1'b0;
                    lit_seen_d = 1'b0;
                end
            end
            ST_FLUSH: begin
                // Busy falls only once the serializer's latch period has elapsed.
                if (!drv_busy) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                    frame_busy_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        rd_en      = (state_q == ST_FETCH) || pf_issue_q;
        rd_addr    = pf_issue_q ? (idx_q + AW'(1)) : idx_q;
        drv_valid  = (state_q == ST_PRESENT);
        drv_last   = ((state_q == ST_PRESENT) || (state_q == ST_XMIT)) && last_pix;
        drv_data   = drv_data_q;
        frame_busy = frame_busy_q;
        frame_done = frame_done_q;
        error      = error_q;
    end

endmodule
